fsm_par: RTL and testbench
==========================

FSM_PAR -- requirements
Module: fsm_par

Interface
REQ-001 Parameter: N, default 3, number of child enables (legal 1..8).
REQ-002 Parameter: CNT_W, default 16, width of the cycle counter.
REQ-003 Port: clk  input  1  single clock; all state updates on posedge clk.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: valid  input  1  start request from the parent controller.
REQ-006 Port: ready  output  1  completion indication to the parent controller.
REQ-007 Port: valid_child  output  N  per-child enable, one bit per child, fed to each child's valid input.
REQ-008 Port: ready_child  input  N  per-child completion, one bit per child, taken from each child's ready output.
REQ-009 Port: cycles  output  CNT_W  RUN-cycle count; present only when FSM_PAR_CYCLE_COUNT_EN is defined.

Function
REQ-010 Block SHALL run N children concurrently and assert ready only after every child has reported ready at least once.
REQ-011 State machine SHALL have three states: IDLE, RUN and DONE.
REQ-012 IDLE: all outputs 0; valid=1 -> RUN at the next edge; otherwise stay in IDLE.
REQ-013 RUN: valid_child[i] = 1 while done[i]=0; valid_child[i] = 0 once done[i]=1; ready=0.
REQ-014 RUN: done[i] SHALL set at the edge where ready_child[i]=1 and remain sticky, even if ready_child[i] later drops.
REQ-015 RUN -> DONE at the edge where (done | ready_child) is all ones; simultaneous completions of several children in one cycle SHALL be honoured.
REQ-016 DONE: ready=1 and valid_child all 0; stay in DONE while valid=1; valid=0 -> IDLE with done cleared.
REQ-017 Minimum latency: valid high in cycle 0 with all children ready in cycle 1 -> ready=1 in cycle 2.
REQ-018 Deasserting valid during RUN SHALL NOT abort: block completes to DONE, asserts ready for one cycle, then returns to IDLE.
REQ-019 ready_child SHALL be ignored in IDLE and DONE.
REQ-020 N=1 SHALL behave as a single-child enable wrapper with the same timing.
REQ-021 All outputs SHALL be decoded from registered state only, so there is no combinational path from any input to any output.

Reset
REQ-022 reset=1 SHALL immediately force state to IDLE, done to 0, ready to 0, valid_child to 0 and cycles to 0, independent of clk.
REQ-023 Reset mid-RUN SHALL discard partial completion; the next valid SHALL restart every child.
REQ-024 First valid sampled SHALL be at the first posedge after reset deasserts.

Configuration
REQ-025 With FSM_PAR_CYCLE_COUNT_EN defined:
  - cycles clears to 0 on the IDLE->RUN edge.
  - cycles increments once per RUN cycle.
  - cycles holds in DONE and IDLE.
  - cycles saturates at 2^CNT_W-1.
REQ-026 Without FSM_PAR_CYCLE_COUNT_EN: no cycles port, no counter logic; all other behaviour is identical.

Structure
REQ-027 Shared package calyx_fsm_pkg SHALL hold the state enum typedef (IDLE, RUN, DONE) and its 2-bit encoding constants.
REQ-028 Per-child logic (sticky done bit plus valid_child gating) SHALL live in the sub-module fsm_par_slot, instantiated N times via generate.

Verification
REQ-029 N=3, reset then valid=1; all ready_child=3'b111 in first RUN cycle -> ready=1 two cycles after valid; valid_child=3'b111 for exactly one cycle.
REQ-030 N=3, staggered completion: ready_child pulses bit0 at cycle 2, bit2 at cycle 4, bit1 at cycle 7:
  - valid_child = 3'b110 from cycle 3.
  - valid_child = 3'b010 from cycle 5.
  - ready=1 at cycle 8.
  - cycles=7.
REQ-031 Sticky done: ready_child[1] pulses high for one cycle, then stays low while the others complete -> ready asserts and child 1 is not re-enabled.
REQ-032 Reset mid-RUN after child 0 is done: all outputs 0 immediately; new valid -> valid_child=3'b111.
REQ-033 valid dropped during RUN: ready pulses exactly one cycle at completion, then state returns to IDLE.
REQ-034 CNT_W=4, a child held not-ready for 20 cycles -> cycles saturates at 15; rebuild without the macro -> port absent and REQ-029 still passes.

Source files
------------

// File: rtl/calyx_fsm_pkg.sv
// calyx_fsm_pkg: shared state encoding for the parallel-enable controller.
// The three controller states and their 2-bit codes are defined here.
package calyx_fsm_pkg;

    localparam logic [1:0] ENC_IDLE = 2'd0;
    localparam logic [1:0] ENC_RUN  = 2'd1;
    localparam logic [1:0] ENC_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ENC_IDLE,
        RUN  = ENC_RUN,
        DONE = ENC_DONE
    } fsm_state_e;

endpackage : calyx_fsm_pkg

// File: rtl/fsm_par_slot.sv
// fsm_par_slot: per-child bookkeeping for fsm_par.
// Holds the sticky completion bit for one child. It also holds the registered
// enable that drives that child's valid input.
module fsm_par_slot (
    input  logic clk,
    input  logic reset,
    input  logic i_start,        // IDLE -> RUN edge: re-enable this child
    input  logic i_run,          // controller is in RUN
    input  logic i_clear,        // DONE -> IDLE edge: forget completion
    input  logic i_ready_child,  // child's ready output
    output logic o_done,
    output logic o_valid_child
);

    logic r_done;
    logic r_valid_child;

    // Sticky done bit and enable: set on start, latched off by the first ready in RUN.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_done        <= 1'b0;
            r_valid_child <= 1'b0;
        end else if (i_start) begin
            r_done        <= 1'b0;
            r_valid_child <= 1'b1;
        end else if (i_clear) begin
            r_done        <= 1'b0;
            r_valid_child <= 1'b0;
        end else if (i_run && i_ready_child) begin
            r_done        <= 1'b1;
            r_valid_child <= 1'b0;
        end
    end

    assign o_done        = r_done;
    assign o_valid_child = r_valid_child;

endmodule : fsm_par_slot

// File: rtl/fsm_par.sv
// fsm_par: runs N children concurrently and reports ready once all have finished.
// Optional RUN-cycle counter and 'cycles' port: define FSM_PAR_CYCLE_COUNT_EN.
// Every output comes straight from a flop, so there is no input-to-output path.
module fsm_par
    import calyx_fsm_pkg::*;
#(
    parameter int N     = 3,   // number of children, 1..8
    parameter int CNT_W = 16   // cycle counter width
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    output logic             ready,
    output logic [N-1:0]     valid_child,
    input  logic [N-1:0]     ready_child
`ifdef FSM_PAR_CYCLE_COUNT_EN
    ,
    output logic [CNT_W-1:0] cycles
`endif
);

    fsm_state_e   r_state;
    logic         r_ready;

    logic         w_start;
    logic         w_run;
    logic         w_clear;
    logic         w_all_done;
    logic [N-1:0] w_done;
    logic [N-1:0] w_valid_child;

    assign w_start = (r_state == IDLE) && valid;
    assign w_run   = (r_state == RUN);
    assign w_clear = (r_state == DONE) && !valid;

    // A child finishing in this very cycle counts too, so several children can
    // complete together and the last one does not cost an extra cycle.
    assign w_all_done = &(w_done | ready_child);

    for (genvar g = 0; g < N; g++) begin : g_slot
        fsm_par_slot u_slot (
            .clk           (clk),
            .reset         (reset),
            .i_start       (w_start),
            .i_run         (w_run),
            .i_clear       (w_clear),
            .i_ready_child (ready_child[g]),
            .o_done        (w_done[g]),
            .o_valid_child (w_valid_child[g])
        );
    end

    // Controller state machine; ready is registered alongside the state.
    // NOTE: asynchronous reset sits in the sensitivity list, so it acts without a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (valid) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    // valid is deliberately ignored here: a started run always completes.
                    if (w_all_done) begin
                        r_state <= DONE;
                        r_ready <= 1'b1;
                    end
                end
                DONE: begin
                    if (!valid) begin
                        r_state <= IDLE;
                        r_ready <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign ready       = r_ready;
    assign valid_child = w_valid_child;

`ifdef FSM_PAR_CYCLE_COUNT_EN
    logic [CNT_W-1:0] r_cycles;

    // RUN-cycle counter: cleared on start, saturating increment in RUN, held elsewhere.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cycles <= '0;
        end else if (w_start) begin
            r_cycles <= '0;
        end else if (w_run && (r_cycles != {CNT_W{1'b1}})) begin
            r_cycles <= r_cycles + CNT_W'(1);
        end
    end

    assign cycles = r_cycles;
`else
    // The counter width parameter is unused without the counter.
    logic w_unused_cnt_w;
    assign w_unused_cnt_w = (CNT_W > 0);
`endif

endmodule : fsm_par

// File: tb/tb_fsm_par.sv
// tb_fsm_par: directed, table-driven bench for fsm_par (N=3), plus an N=1 instance.
// Build with FSM_PAR_CYCLE_COUNT_EN defined to also check the cycle counter.
module tb_fsm_par;

    logic       clk;
    logic       reset;
    logic       valid;
    logic       ready;
    logic [2:0] valid_child;
    logic [2:0] ready_child;

    // Second instance: N=1, CNT_W=4 (single-child wrapper and counter saturation)
    logic       s_valid;
    logic       s_ready;
    logic [0:0] s_valid_child;
    logic [0:0] s_ready_child;

`ifdef FSM_PAR_CYCLE_COUNT_EN
    logic [15:0] cycles;
    logic [3:0]  s_cycles;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    fsm_par #(.N(3), .CNT_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .valid       (valid),
        .ready       (ready),
        .valid_child (valid_child),
        .ready_child (ready_child)
`ifdef FSM_PAR_CYCLE_COUNT_EN
        ,
        .cycles      (cycles)
`endif
    );

    fsm_par #(.N(1), .CNT_W(4)) dut_n1 (
        .clk         (clk),
        .reset       (reset),
        .valid       (s_valid),
        .ready       (s_ready),
        .valid_child (s_valid_child),
        .ready_child (s_ready_child)
`ifdef FSM_PAR_CYCLE_COUNT_EN
        ,
        .cycles      (s_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic [2:0] rdy;
        logic       exp_ready;
        logic [2:0] exp_vc;
        int         exp_cyc;   // -1: counter not checked on this row
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic v, input logic [2:0] r, input logic er,
                       input logic [2:0] evc, input int ec);
        vec_t t;
        t.valid     = v;
        t.rdy       = r;
        t.exp_ready = er;
        t.exp_vc    = evc;
        t.exp_cyc   = ec;
        vecs.push_back(t);
    endtask

    initial begin
        // Each row: inputs driven during one cycle, outputs expected in that cycle.
        // Minimum latency: all children ready in the first RUN cycle.
        add(1, 3'b000, 0, 3'b000, -1);  // c0 IDLE, valid sampled
        add(1, 3'b111, 0, 3'b111, -1);  // c1 RUN
        add(1, 3'b000, 1, 3'b000,  1);  // c2 DONE
        add(0, 3'b111, 1, 3'b000, -1);  // c3 DONE, ready_child ignored
        add(0, 3'b111, 0, 3'b000,  1);  // c4 IDLE, ready_child ignored
        add(0, 3'b000, 0, 3'b000, -1);
        // Staggered completion: bit0 @2, bit2 @4, bit1 @7
        add(1, 3'b000, 0, 3'b000, -1);  // c0
        add(1, 3'b000, 0, 3'b111, -1);  // c1
        add(1, 3'b001, 0, 3'b111, -1);  // c2
        add(1, 3'b000, 0, 3'b110, -1);  // c3
        add(1, 3'b100, 0, 3'b110, -1);  // c4
        add(1, 3'b000, 0, 3'b010, -1);  // c5
        add(1, 3'b000, 0, 3'b010, -1);  // c6
        add(1, 3'b010, 0, 3'b010, -1);  // c7
        add(1, 3'b000, 1, 3'b000,  7);  // c8
        add(0, 3'b000, 1, 3'b000,  7);  // c9
        add(0, 3'b000, 0, 3'b000,  7);  // c10
        // Sticky done: child 1 pulses once, never re-enabled
        add(1, 3'b000, 0, 3'b000, -1);  // c0
        add(1, 3'b010, 0, 3'b111, -1);  // c1
        add(1, 3'b000, 0, 3'b101, -1);  // c2
        add(1, 3'b000, 0, 3'b101, -1);  // c3
        add(1, 3'b101, 0, 3'b101, -1);  // c4
        add(1, 3'b000, 1, 3'b000,  4);  // c5
        add(0, 3'b000, 1, 3'b000,  4);  // c6
        add(0, 3'b000, 0, 3'b000, -1);  // c7
        // valid dropped during RUN: still completes, ready pulses one cycle
        add(1, 3'b000, 0, 3'b000, -1);  // c0
        add(0, 3'b000, 0, 3'b111, -1);  // c1
        add(0, 3'b011, 0, 3'b111, -1);  // c2
        add(0, 3'b100, 0, 3'b100, -1);  // c3
        add(0, 3'b000, 1, 3'b000,  3);  // c4
        add(0, 3'b000, 0, 3'b000,  3);  // c5
        add(0, 3'b000, 0, 3'b000,  3);  // c6

        // Reset: outputs forced low with no clock edge involved
        reset         = 1'b1;
        valid         = 1'b0;
        ready_child   = 3'b000;
        s_valid       = 1'b0;
        s_ready_child = 1'b0;
        #3;
        check("reset ready", ready, 0);
        check("reset valid_child", valid_child, 0);
        check("reset n1 ready", s_ready, 0);
        check("reset n1 valid_child", s_valid_child, 0);
`ifdef FSM_PAR_CYCLE_COUNT_EN
        check("reset cycles", cycles, 0);
`endif
        step();
        step();
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            valid       = vecs[i].valid;
            ready_child = vecs[i].rdy;
            check($sformatf("vec%0d ready", i), ready, vecs[i].exp_ready);
            check($sformatf("vec%0d valid_child", i), valid_child, vecs[i].exp_vc);
`ifdef FSM_PAR_CYCLE_COUNT_EN
            if (vecs[i].exp_cyc >= 0)
                check($sformatf("vec%0d cycles", i), cycles, vecs[i].exp_cyc);
`endif
            step();
        end

        // Reset mid-RUN after child 0 completed; next run re-enables every child
        valid       = 1'b1;
        ready_child = 3'b000;
        step();                         // RUN
        ready_child = 3'b001;
        step();
        ready_child = 3'b000;
        check("midrun pre-reset valid_child", valid_child, 3'b110);
        #2;
        reset = 1'b1;
        #1;
        check("midrun reset ready", ready, 0);
        check("midrun reset valid_child", valid_child, 0);
`ifdef FSM_PAR_CYCLE_COUNT_EN
        check("midrun reset cycles", cycles, 0);
`endif
        step();
        reset = 1'b0;
        valid = 1'b1;
        step();
        check("restart valid_child", valid_child, 3'b111);
        ready_child = 3'b111;
        step();
        ready_child = 3'b000;
        check("restart ready", ready, 1);
        valid = 1'b0;
        step();
        check("restart back to idle", ready, 0);

        // N=1 instance: child held off for 20 RUN cycles, counter saturates
        s_valid = 1'b1;
        check("n1 idle valid_child", s_valid_child, 0);
        step();
        check("n1 run valid_child", s_valid_child, 1);
        for (int i = 0; i < 20; i++) step();
        check("n1 held valid_child", s_valid_child, 1);
        check("n1 held ready", s_ready, 0);
        s_ready_child = 1'b1;
        step();
        s_ready_child = 1'b0;
        check("n1 done ready", s_ready, 1);
        check("n1 done valid_child", s_valid_child, 0);
`ifdef FSM_PAR_CYCLE_COUNT_EN
        check("n1 cycles saturated", s_cycles, 15);
`endif
        s_valid = 1'b0;
        step();
        check("n1 back to idle", s_ready, 0);
        // Minimum latency on N=1
        s_valid = 1'b1;
        step();
        s_ready_child = 1'b1;
        step();
        s_ready_child = 1'b0;
        check("n1 min latency ready", s_ready, 1);
        s_valid = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_fsm_par
